// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the arbiter FSM state type.
package alu_pkg;

    // Opcodes at or above this value are illegal.
    localparam int unsigned ALU_NUM_OPS = 5;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_AND = 2;
    localparam int unsigned ALU_OR  = 3;
    localparam int unsigned ALU_XOR = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/xor with signed-overflow, sign and zero flags.
module alu
    import alu_pkg::*;
#(
    parameter int word_len = 32,
    parameter int op_len   = 8
) (
    input  logic [op_len-1:0]   op,
    input  logic [word_len-1:0] x,
    input  logic [word_len-1:0] y,
    output logic [word_len-1:0] ans,
    output logic                did_overflow,
    output logic                is_negative,
    output logic                is_zero
);

    // Result and signed overflow; illegal opcodes yield zero with no overflow.
    always_comb begin
        ans          = '0;
        did_overflow = 1'b0;
        case (op)
            op_len'(ALU_ADD): begin
                ans          = x + y;
                did_overflow = (x[word_len-1] == y[word_len-1]) &&
                               (ans[word_len-1] != x[word_len-1]);
            end
            op_len'(ALU_SUB): begin
                ans          = x - y;
                did_overflow = (x[word_len-1] != y[word_len-1]) &&
                               (ans[word_len-1] != x[word_len-1]);
            end
            op_len'(ALU_AND): ans = x & y;
            op_len'(ALU_OR):  ans = x | y;
            op_len'(ALU_XOR): ans = x ^ y;
            default:          ans = '0;
        endcase
    end

    assign is_negative = ans[word_len-1];
    assign is_zero     = (ans == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or above ptr, with wrap.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx
);

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, registered
// operands, one execute cycle, and a response held until the consumer takes it.
//
// Handshakes: a request transfers on a clock edge where req_valid[i] and
// req_ready[i] are both high; the response transfers on an edge where
// resp_valid and resp_ready are both high. A requester holds valid and its
// payload stable until ready; resp_* stay stable while resp_valid is waiting.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int  word_len = 32,
    parameter int  op_len   = 8,
    parameter int  NUM_REQ  = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*op_len-1:0]    req_op,
    input  logic [NUM_REQ*word_len-1:0]  req_x,
    input  logic [NUM_REQ*word_len-1:0]  req_y,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ID_W-1:0]              resp_id,
    output logic [word_len-1:0]          resp_ans,
    output logic                         resp_ovf,
    output logic                         resp_neg,
    output logic                         resp_zer,
    output logic                         resp_err,
    output logic [1:0]                   dbg_state
);

    arb_state_t          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]     id_q;
    logic [op_len-1:0]   op_q;
    logic [word_len-1:0] x_q;
    logic [word_len-1:0] y_q;
    logic [word_len-1:0] alu_ans;
    logic                alu_ovf;
    logic                alu_neg;
    logic                alu_zer;
    logic                op_bad;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req          (req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    // The ALU only ever sees the latched operands, never the live request bus.
    alu #(.word_len(word_len), .op_len(op_len)) u_alu (
        .op           (op_q),
        .x            (x_q),
        .y            (y_q),
        .ans          (alu_ans),
        .did_overflow (alu_ovf),
        .is_negative  (alu_neg),
        .is_zero      (alu_zer)
    );

    // Accept strobe exists only in IDLE and is held off while reset is asserted.
    assign req_ready = (rst_n && state == IDLE) ? grant_onehot : '0;
    assign op_bad    = (op_q >= op_len'(ALU_NUM_OPS));
    assign dbg_state = state;

    // FSM, round-robin pointer and operand latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            op_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant_onehot) begin
                        id_q   <= grant_idx;
                        op_q   <= req_op[int'(grant_idx)*op_len +: op_len];
                        x_q    <= req_x[int'(grant_idx)*word_len +: word_len];
                        y_q    <= req_y[int'(grant_idx)*word_len +: word_len];
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0
                                                                  : grant_idx + ID_W'(1);
                        state  <= EXEC;
                    end
                end
                EXEC:    state <= RESP;
                RESP:    if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Response registers: captured at the end of EXEC, held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_ans   <= '0;
            resp_ovf   <= 1'b0;
            resp_neg   <= 1'b0;
            resp_zer   <= 1'b0;
            resp_err   <= 1'b0;
        end else if (state == EXEC) begin
            resp_valid <= 1'b1;
            resp_id    <= id_q;
            resp_ans   <= op_bad ? '0 : alu_ans;
            resp_ovf   <= op_bad ? 1'b0 : alu_ovf;
            resp_neg   <= op_bad ? 1'b0 : alu_neg;
            resp_zer   <= op_bad ? 1'b0 : alu_zer;
            resp_err   <= op_bad;
        end else if (state == RESP && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table for single operations plus
// hand-written sequences for contention, backpressure and mid-op reset.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*8-1:0]  req_op;
    logic [N*W-1:0]  req_x;
    logic [N*W-1:0]  req_y;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [W-1:0]    resp_ans;
    logic            resp_ovf;
    logic            resp_neg;
    logic            resp_zer;
    logic            resp_err;
    logic [1:0]      dbg_state;

    int errors = 0;
    int checks = 0;

    // scoreboard entry: {id, ans}
    logic [33:0] exp_q[$];
    int          grant_q[$];

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ans;
        logic [3:0]  flg;   // {ovf, neg, zer, err}
    } vec_t;

    vec_t vecs[10];

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_ans   (resp_ans),
        .resp_ovf   (resp_ovf),
        .resp_neg   (resp_neg),
        .resp_zer   (resp_zer),
        .resp_err   (resp_err),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    // driver / checker tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [7:0] op, input logic [31:0] x,
                           input logic [31:0] y);
        req_op[id*8 +: 8] = op;
        req_x[id*W +: W]  = x;
        req_y[id*W +: W]  = y;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ready"}, req_ready, 0);
        check({name, "_valid"}, resp_valid, 0);
        check({name, "_id"}, resp_id, 0);
        check({name, "_ans"}, resp_ans, 0);
        check({name, "_flags"}, {resp_ovf, resp_neg, resp_zer, resp_err}, 0);
        check({name, "_state"}, dbg_state, IDLE);
    endtask

    // Bounded wait for a response, compare it, then accept it.
    task automatic wait_resp(input string name, input logic [1:0] id, input logic [31:0] ans);
        bit got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            #1;
            if (resp_valid) got = 1;
        end
        check({name, "_seen"}, got, 1);
        if (got) begin
            check({name, "_id"}, resp_id, id);
            check({name, "_ans"}, resp_ans, ans);
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end
    endtask

    initial begin
        int       last_grant;
        int       grants;
        int       exp_id;
        logic [33:0] e;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;

        vecs[0] = '{2'd2, 8'd0, 32'd7,          32'hFFFF_FFFD, 32'd4,          4'b0000};
        vecs[1] = '{2'd0, 8'd1, 32'd5,          32'd5,         32'd0,          4'b0010};
        vecs[2] = '{2'd3, 8'd0, 32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  4'b1100};
        vecs[3] = '{2'd1, 8'd9, 32'd3,          32'd4,         32'd0,          4'b0001};
        vecs[4] = '{2'd1, 8'd2, 32'hF0F0_F0F0,  32'hFF00_FF00, 32'hF000_F000,  4'b0100};
        vecs[5] = '{2'd0, 8'd3, 32'h0000_000F,  32'h0000_00F0, 32'h0000_00FF,  4'b0000};
        vecs[6] = '{2'd2, 8'd4, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,          4'b0010};
        vecs[7] = '{2'd3, 8'd1, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  4'b1000};
        vecs[8] = '{2'd1, 8'd1, 32'd3,          32'd5,         32'hFFFF_FFFE,  4'b0100};
        vecs[9] = '{2'd0, 8'd5, 32'd1,          32'd1,         32'd0,          4'b0001};

        // reset state, with requests asserted to show no accept during reset
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1;
        check_all_zero("reset");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // contention: all valid, consumer always ready
        for (int i = 0; i < N; i++) set_req(i, 8'(ALU_ADD), 32'(i + 1), 32'd10);
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        grant_q    = '{0, 1, 2, 3, 0};
        last_grant = -1;
        grants     = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req_ready != '0) begin
                grants++;
                if (grant_q.size() == 0) begin
                    check("cont_extra_grant", req_ready, 0);
                end else begin
                    exp_id = grant_q.pop_front();
                    check("cont_grant", req_ready, 64'(1) << exp_id);
                    if (last_grant >= 0) check("cont_spacing", c - last_grant, 3);
                    last_grant = c;
                    exp_q.push_back({2'(exp_id), 32'(exp_id + 11)});
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("cont_unexpected_resp", resp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cont_resp", {resp_id, resp_ans}, e);
                end
            end
            @(negedge clk);
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        check("cont_grants", grants, 5);
        check("cont_drained", exp_q.size(), 0);

        // table-driven single operations
        foreach (vecs[v]) begin
            @(negedge clk);
            set_req(int'(vecs[v].id), vecs[v].op, vecs[v].x, vecs[v].y);
            req_valid = 4'(1) << vecs[v].id;
            #1;
            check($sformatf("vec%0d_ready", v), req_ready, 64'(1) << vecs[v].id);
            @(negedge clk);
            req_valid = '0;
            #1;
            check($sformatf("vec%0d_exec_novalid", v), resp_valid, 0);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_valid", v), resp_valid, 1);
            check($sformatf("vec%0d_id", v), resp_id, vecs[v].id);
            check($sformatf("vec%0d_ans", v), resp_ans, vecs[v].ans);
            check($sformatf("vec%0d_flags", v), {resp_ovf, resp_neg, resp_zer, resp_err},
                  vecs[v].flg);
            resp_ready = 1'b1;
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_cleared", v), {resp_valid, dbg_state}, {1'b0, IDLE});
            resp_ready = 1'b0;
        end

        // backpressure: SUB 5-5 held for 6 cycles while requester 1 waits
        @(negedge clk);
        set_req(0, 8'(ALU_SUB), 32'd5, 32'd5);
        set_req(1, 8'(ALU_ADD), 32'd100, 32'd1);
        req_valid = 4'b0001;
        #1;
        check("bp_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("bp_exec", {dbg_state, req_ready}, {EXEC, 4'b0000});
        @(negedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            check("bp_hold_valid", resp_valid, 1);
            check("bp_hold_data", {resp_id, resp_ans}, {2'd0, 32'd0});
            check("bp_hold_flags", {resp_ovf, resp_neg, resp_zer, resp_err}, 4'b0010);
            check("bp_no_ready", req_ready, 0);
            @(negedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        check("bp_release_state", dbg_state, IDLE);
        check("bp_release_valid", resp_valid, 0);
        check("bp_next_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        wait_resp("bp_r1", 2'd1, 32'd101);

        // reset in EXEC: requester 2 in flight (pointer would otherwise become 3)
        @(negedge clk);
        set_req(2, 8'(ALU_ADD), 32'd1, 32'd2);
        req_valid = 4'b0100;
        #1;
        check("rst_ready", req_ready, 4'b0100);
        @(negedge clk);
        #1;
        check("rst_in_exec", dbg_state, EXEC);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_now");
        @(negedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1, 8'(ALU_ADD), 32'd20, 32'd22);
        set_req(3, 8'(ALU_XOR), 32'h0000_00FF, 32'h0000_000F);
        req_valid = 4'b1010;
        #1;
        check("rst_ptr_zero", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b1000;
        wait_resp("rst_r1", 2'd1, 32'd42);
        #1;
        check("rst_next_ready", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        wait_resp("rst_r3", 2'd3, 32'h0000_00F0);

        // quiet tail: no spurious responses
        repeat (3) @(negedge clk);
        #1;
        check("tail_idle", {resp_valid, dbg_state}, {1'b0, IDLE});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
